// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-shot/auto-reload and a registered borrow pulse.
// Define COUNTDOWN_TIMER_PRESCALE_EN to decrement only on every PRESCALE-th en tick in RUN.
module countdown_timer #(
   parameter int WIDTH = 4
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
   ,
   parameter int PRESCALE = 4
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             auto_reload,
   output logic             bo,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] counter
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [WIDTH-1:0] counter_q, counter_d, reload_q, reload_d;
   logic bo_q, bo_d;
   logic step;
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   logic [PW-1:0] pre_q, pre_d;
   logic tick;
   always_comb begin
      tick = (state_q == RUN) && en;
      step = tick && (pre_q == PW'(PRESCALE - 1));
      pre_d = (load || step) ? '0 : tick ? pre_q + PW'(1) : pre_q;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) pre_q <= '0;
      else pre_q <= pre_d;
`else
   assign step = (state_q == RUN) && en;
`endif
   // RUN never holds counter==0, so the terminal tick is always the step at 1
   always_comb begin
      counter_d = counter_q;
      reload_d = reload_q;
      state_d = state_q;
      bo_d = 1'b0;
      if (load) begin
         counter_d = load_val;
         reload_d = load_val;
         state_d = (load_val != '0) ? RUN : IDLE;
      end else if (step && counter_q > WIDTH'(1)) begin
         counter_d = counter_q - WIDTH'(1);
      end else if (step && counter_q == WIDTH'(1)) begin
         bo_d = 1'b1;
         counter_d = auto_reload ? reload_q : '0;
         state_d = auto_reload ? RUN : DONE;
      end
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q <= IDLE;
         counter_q <= '0;
         reload_q <= '0;
         bo_q <= 1'b0;
      end else begin
         state_q <= state_d;
         counter_q <= counter_d;
         reload_q <= reload_d;
         bo_q <= bo_d;
      end
   assign bo = bo_q;
   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign counter = counter_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed vectors feed a scoreboard queue; a monitor compares each cycle's outputs.
module tb_countdown_timer;
   typedef struct packed {
      logic [3:0] cnt;
      logic bo, busy, done;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en = 1'b0, load = 1'b0, auto_reload = 1'b0;
   logic [3:0] load_val = '0;
   logic bo, busy, done;
   logic [3:0] counter;
   int total = 0, bad = 0;
   exp_t sb[$];
   exp_t e;
   countdown_timer #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
      .auto_reload(auto_reload), .bo(bo), .busy(busy), .done(done), .counter(counter)
   );
   always #5 clk = ~clk;
   always @(posedge clk) begin
      #1;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         total++;
         if ({counter, bo, busy, done} != e) begin
            bad++;
            $display("FAIL cycle t=%0t: got cnt=%0d bo=%0b busy=%0b done=%0b, want cnt=%0d bo=%0b busy=%0b done=%0b",
                     $time, counter, bo, busy, done, e.cnt, e.bo, e.busy, e.done);
         end
      end
   end
   task automatic step(input logic e_i, l_i, input logic [3:0] lv, input logic ar,
                       input logic [3:0] c, input logic b, bz, d);
      @(negedge clk);
      en = e_i;
      load = l_i;
      load_val = lv;
      auto_reload = ar;
      sb.push_back({c, b, bz, d});
   endtask
   task automatic check_now(input string name, input logic [3:0] c, input logic b, bz, d);
      total++;
      if ({counter, bo, busy, done} != {c, b, bz, d}) begin
         bad++;
         $display("FAIL %s: got cnt=%0d bo=%0b busy=%0b done=%0b, want cnt=%0d bo=%0b busy=%0b done=%0b",
                  name, counter, bo, busy, done, c, b, bz, d);
      end
   endtask
   task automatic drain();
      @(negedge clk);
      en = 1'b0;
      load = 1'b0;
      @(posedge clk);
      #3;
   endtask
   task automatic release_rst();
      @(negedge clk);
      rst = 1'b1;
   endtask
   initial begin
      #1 check_now("reset_at_start", 0, 0, 0, 0);
      @(posedge clk);
      #1 check_now("reset_held_over_edge", 0, 0, 0, 0);
      release_rst();
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
      step(0, 1, 2, 0, 2, 0, 1, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 2, 0, 1, 0);
      step(1, 0, 0, 0, 1, 0, 1, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 0, 1, 0);
      step(1, 0, 0, 0, 0, 1, 0, 1);
      step(1, 0, 0, 0, 0, 0, 0, 1);
      step(0, 1, 1, 0, 1, 0, 1, 0);
      step(1, 0, 0, 0, 1, 0, 1, 0);
      step(1, 0, 0, 0, 1, 0, 1, 0);
      step(1, 1, 1, 0, 1, 0, 1, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 0, 1, 0);
      step(1, 0, 0, 0, 0, 1, 0, 1);
`else
      step(0, 1, 3, 0, 3, 0, 1, 0);
      step(1, 0, 0, 0, 2, 0, 1, 0);
      step(1, 0, 0, 0, 1, 0, 1, 0);
      step(1, 0, 0, 0, 0, 1, 0, 1);
      step(1, 0, 0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0, 0, 1);
      step(0, 1, 2, 1, 2, 0, 1, 0);
      for (int i = 0; i < 6; i++) step(1, 0, 0, 1, (i % 2 == 0) ? 4'd1 : 4'd2, i % 2 == 1, 1, 0);
      step(0, 0, 0, 1, 2, 0, 1, 0);
      step(0, 1, 1, 1, 1, 0, 1, 0);
      step(1, 0, 0, 1, 1, 1, 1, 0);
      step(1, 0, 0, 1, 1, 1, 1, 0);
      step(1, 0, 0, 1, 1, 1, 1, 0);
      step(0, 0, 0, 1, 1, 0, 1, 0);
      step(0, 1, 4, 0, 4, 0, 1, 0);
      step(1, 0, 0, 0, 3, 0, 1, 0);
      step(0, 0, 0, 0, 3, 0, 1, 0);
      step(1, 0, 0, 0, 2, 0, 1, 0);
      step(0, 0, 0, 0, 2, 0, 1, 0);
      step(1, 1, 9, 0, 9, 0, 1, 0);
      step(1, 0, 0, 0, 8, 0, 1, 0);
      step(0, 1, 1, 0, 1, 0, 1, 0);
      step(1, 1, 5, 0, 5, 0, 1, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 15, 0, 15, 0, 1, 0);
      for (int k = 1; k <= 15; k++) step(1, 0, 0, 0, 4'(15 - k), k == 15, k < 15, k == 15);
      step(1, 0, 0, 0, 0, 0, 0, 1);
      step(0, 1, 2, 0, 2, 0, 1, 0);
`endif
      drain();
      step(0, 1, 5, 0, 5, 0, 1, 0);
      drain();
      rst = 1'b0;
      #1 check_now("reset_mid_count", 0, 0, 0, 0);
      release_rst();
      step(0, 1, 1, 0, 1, 0, 1, 0);
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 0, 1, 0);
`endif
      step(1, 0, 0, 0, 0, 1, 0, 1);
      drain();
      rst = 1'b0;
      #1 check_now("reset_drops_bo", 0, 0, 0, 0);
      @(posedge clk);
      #1 check_now("reset_held_after_bo", 0, 0, 0, 0);
      release_rst();
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
